// File: rtl/term_pkg.sv
// Shared constants, ASCII codes and FSM state type for the terminal writer.
package term_pkg;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;
  localparam logic [6:0] CH_SP = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_e;
endpackage

// File: rtl/term_addr_gen.sv
// Maps (top_row, logical row, column) onto a physical character-buffer address.
module term_addr_gen
  import term_pkg::*;
(
  input  logic [ROW_W-1:0]  top_row_i,
  input  logic [ROW_W-1:0]  cur_row_i,
  input  logic [COL_W-1:0]  cur_col_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ROW_W:0]   row_sum;
  logic [ROW_W:0]   row_wrap;
  logic [ROW_W-1:0] phys_row;

  // Both operands are < ROWS, so a single conditional subtract implements mod ROWS.
  assign row_sum  = {1'b0, top_row_i} + {1'b0, cur_row_i};
  assign row_wrap = (row_sum >= (ROW_W+1)'(ROWS)) ? row_sum - (ROW_W+1)'(ROWS) : row_sum;
  assign phys_row = row_wrap[ROW_W-1:0];
  assign addr_o   = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(cur_col_i);
endmodule

// File: rtl/term_writer.sv
// Keyboard-to-character-buffer writer: cursor, CR/LF/BS handling, circular scroll.
// Optional macro TERM_FF_CLEAR_EN enables form feed (0x0C) clearing the whole screen.
module term_writer
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_data,
  output logic              buf_req,
  input  logic              buf_gnt,
  output logic [ADDR_W-1:0] buf_ad,
  output logic [6:0]        buf_din,
  output logic              buf_wre,
  output logic              buf_ce,
  output logic [ROW_W-1:0]  top_row,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [COL_W-1:0]  cur_col_q, cur_col_d;
  logic [ROW_W-1:0]  cur_row_q, cur_row_d;
  logic [ROW_W-1:0]  top_row_q, top_row_d;
  logic [ADDR_W-1:0] buf_ad_q, buf_ad_d;
  logic [6:0]        buf_din_q, buf_din_d;
  logic [COL_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              adv_q, adv_d;
  logic              newline;
  logic [COL_W-1:0]  col_sel;
  logic [ADDR_W-1:0] cell_addr;
  logic [ADDR_W-1:0] line_base;

  // Backspace targets the cell left of the cursor; everything else the cursor cell.
  assign col_sel = (in_data == CH_BS) ? cur_col_q - 1'b1 : cur_col_q;

  term_addr_gen u_cell_addr (
    .top_row_i (top_row_q),
    .cur_row_i (cur_row_q),
    .cur_col_i (col_sel),
    .addr_o    (cell_addr)
  );

  // The row exposed by a scroll is the physical row currently at the top.
  term_addr_gen u_line_base (
    .top_row_i (top_row_q),
    .cur_row_i ('0),
    .cur_col_i ('0),
    .addr_o    (line_base)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cur_col_q <= '0;
      cur_row_q <= '0;
      top_row_q <= '0;
      buf_ad_q  <= '0;
      buf_din_q <= '0;
      clr_cnt_q <= '0;
      adv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      top_row_q <= top_row_d;
      buf_ad_q  <= buf_ad_d;
      buf_din_q <= buf_din_d;
      clr_cnt_q <= clr_cnt_d;
      adv_q     <= adv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    top_row_d = top_row_q;
    buf_ad_d  = buf_ad_q;
    buf_din_d = buf_din_q;
    clr_cnt_d = clr_cnt_q;
    adv_d     = adv_q;
    newline   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if ((in_data >= 7'h20) && (in_data <= 7'h7E)) begin
            buf_ad_d  = cell_addr;
            buf_din_d = in_data;
            adv_d     = 1'b1;
            state_d   = ST_WRITE;
          end else if (in_data == CH_CR) begin
            cur_col_d = '0;
          end else if (in_data == CH_LF) begin
            newline = 1'b1;
          end else if (in_data == CH_BS) begin
            if (cur_col_q != '0) begin
              cur_col_d = col_sel;
              buf_ad_d  = cell_addr;
              buf_din_d = CH_SP;
              adv_d     = 1'b0;
              state_d   = ST_WRITE;
            end
`ifdef TERM_FF_CLEAR_EN
          end else if (in_data == CH_FF) begin
            buf_ad_d  = '0;
            buf_din_d = CH_SP;
            state_d   = ST_CLR_ALL;
`endif
          end
        end
      end
      ST_WRITE: begin
        if (buf_gnt) begin
          state_d = ST_IDLE;
          if (adv_q) begin
            if (cur_col_q == COL_W'(COLS-1)) newline = 1'b1;
            else cur_col_d = cur_col_q + 1'b1;
          end
        end
      end
      ST_CLR_LINE: begin
        if (buf_gnt) begin
          if (clr_cnt_q == COL_W'(COLS-1)) begin
            state_d = ST_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            buf_ad_d  = buf_ad_q + 1'b1;
          end
        end
      end
`ifdef TERM_FF_CLEAR_EN
      ST_CLR_ALL: begin
        if (buf_gnt) begin
          if (buf_ad_q == ADDR_W'(ROWS*COLS-1)) begin
            cur_col_d = '0;
            cur_row_d = '0;
            top_row_d = '0;
            state_d   = ST_IDLE;
          end else begin
            buf_ad_d = buf_ad_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Newline: at the bottom row the screen scrolls and the exposed line is cleared.
    if (newline) begin
      cur_col_d = '0;
      if (cur_row_q < ROW_W'(ROWS-1)) begin
        cur_row_d = cur_row_q + 1'b1;
      end else begin
        top_row_d = (top_row_q == ROW_W'(ROWS-1)) ? '0 : top_row_q + 1'b1;
        buf_ad_d  = line_base;
        buf_din_d = CH_SP;
        clr_cnt_d = '0;
        state_d   = ST_CLR_LINE;
      end
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign buf_req  = (state_q != ST_IDLE);
  assign buf_wre  = buf_req & buf_gnt;
  assign buf_ce   = buf_wre;
  assign buf_ad   = buf_ad_q;
  assign buf_din  = buf_din_q;
  assign top_row  = top_row_q;
  assign cur_col  = cur_col_q;
  assign cur_row  = cur_row_q;
endmodule
